// File: rtl/mem_fill_ctrl.sv
// Memory fill controller: captures a framed valid/ready stream into a 2**ADDR_W x WIDTH memory.
// Define MEM_FILL_CTRL_READBACK_EN to add the registered rd_addr/rd_data readback port.
module mem_fill_ctrl #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 6,
    parameter int AFULL_LVL = (2**ADDR_W) - 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   count,
    output logic              almost_full,
    output logic              memory_full,
    output logic              stop
`ifdef MEM_FILL_CTRL_READBACK_EN
    ,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
`endif
);

    localparam int            DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_LVL);

    typedef enum logic [1:0] {IDLE, WRITE, DONE, FULL} state_t;

    state_t            state, state_nxt;
    logic              restart;
    logic [ADDR_W:0]   count_inc;
    logic [WIDTH-1:0]  mem [DEPTH];

    assign count_inc = count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        stop      = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                in_ready = 1'b1;
                // The last slot wins over in_last so a full buffer always reports FULL
                if (in_valid) begin
                    if (count == LAST_C) state_nxt = FULL;
                    else if (in_last)    state_nxt = DONE;
                end
            end
            DONE, FULL: begin
                stop = 1'b1;
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = WRITE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // rst and clear outrank the stream, so nothing is accepted in that cycle
        if (clear) begin
            state_nxt = IDLE;
            restart   = 1'b0;
            in_ready  = 1'b0;
        end
        if (rst) in_ready = 1'b0;
    end

    assign write       = in_valid & in_ready;
    assign memory_full = (count == DEPTH_C);

    always_ff @(posedge clk) begin
        if (rst || clear || restart) begin
            addr        <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else if (write) begin
            addr        <= addr + 1'b1;
            count       <= count_inc;
            almost_full <= (count_inc >= AFULL_C);
        end
    end

    // No reset on the array: contents survive rst/clear and are undefined at power-up
    always_ff @(posedge clk) begin
        if (write) mem[addr] <= in_data;
    end

`ifdef MEM_FILL_CTRL_READBACK_EN
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end
`endif

endmodule

// File: doc/mem_fill_ctrl.md
# mem_fill_ctrl

Parametrised memory fill controller. It accepts a framed stream of data words over a valid/ready handshake and writes them sequentially into an internal `2**ADDR_W` x `WIDTH` memory. It flags completion and full conditions, and optionally exposes a registered readback port. It is the successor to the fixed 64 x 32 memory driver and sits between a data source and any consumer that drains the captured buffer.

## Interface
- `WIDTH`, default 32: data word width.
- `ADDR_W`, default 6: address width; `DEPTH = 2**ADDR_W`.
- `AFULL_LVL`, default `DEPTH-4`: `almost_full` asserts when `count >= AFULL_LVL`; legal range 1..DEPTH.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a new fill at address 0.
- `clear` input 1: abort and return to IDLE.
- `in_valid` input 1: source has a word.
- `in_data` input `WIDTH`: data word.
- `in_last` input 1: final word of the frame; qualified by acceptance.
- `in_ready` output 1: controller can accept a word.
- `write` output 1: memory write strobe, equal to `in_valid & in_ready` (combinational).
- `addr` output `ADDR_W`: write pointer, registered; the address written when `write` is high.
- `count` output `ADDR_W+1`: number of words stored in the current fill.
- `almost_full` output 1: `count >= AFULL_LVL`, registered.
- `memory_full` output 1: `count == DEPTH`.
- `stop` output 1: high in DONE or FULL.
- `rd_addr` input `ADDR_W`: readback address; present only with the macro.
- `rd_data` output `WIDTH`: readback data; present only with the macro.

## Operation
- FSM states: IDLE, WRITE, DONE, FULL.
- Input priority each cycle: `rst` > `clear` > `start` > stream.
- IDLE:
  - `in_ready=0`.
  - On `start`: `addr=0`, `count=0`, go to WRITE.
- WRITE:
  - `in_ready=1`.
  - On acceptance: `mem[addr] <= in_data`, `addr <= addr+1`, `count <= count+1`.
  - Accepting the word at address `DEPTH-1` forces FULL. This holds even if `in_last=1`; FULL wins.
  - Otherwise, accepting a word with `in_last=1` goes to DONE.
  - `start` in WRITE is ignored.
- DONE and FULL:
  - `in_ready=0` and `stop=1`.
  - `count` and `addr` are held.
  - `start` restarts the fill at address 0; memory contents are not cleared.
- `clear` from any state: go to IDLE, `addr=0`, `count=0`, `almost_full=0`; memory is untouched.
- Reset mid-fill behaves exactly like `clear`.
  - Reset values: IDLE, `addr=0`, `count=0`, `in_ready=0`, `write=0`, `almost_full=0`, `memory_full=0`, `stop=0`.
  - Memory contents are undefined after reset.
- `addr` wraps to 0 after `DEPTH-1`. The FSM is in FULL at that point, so no further writes occur.
- `memory_full` is decoded from the registered `count`. `stop` is decoded from the FSM state.

## Timing
- Write latency: a word is accepted and written on the same rising edge where `in_valid & in_ready`. `count` and `addr` update on that edge.
- State changes (DONE or FULL) are visible the cycle after the accepting edge, so `in_ready` drops that cycle.
- The source may hold `in_valid` high continuously. Throughput is one word per cycle in WRITE.
- With `start` asserted in IDLE, `in_ready` rises one cycle later.
- Readback: `rd_data` is registered with 1-cycle latency.
  - A read and a write to the same address in the same cycle returns the old data.
- `almost_full` follows `count` in the same cycle.

## Configuration
- Macro: `MEM_FILL_CTRL_READBACK_EN`.
- Defined: the `rd_addr`/`rd_data` ports and the registered read path are compiled in.
- Undefined: both ports are absent, and the memory is write-only. An external reader accesses it hierarchically; this is for bench use only.
- Write-path behaviour is identical either way.

## Test plan
- Reset, `start`, then 3 words `0xA0`, `0xA1`, `0xA2` with `in_last` on the third:
  - `write` high for 3 cycles at `addr` 0..2.
  - Then DONE, `count=3`, `stop=1`, `memory_full=0`, `in_ready=0`.
- `start` with `in_valid` held high for `DEPTH+5` cycles:
  - Exactly 64 writes occur.
  - `almost_full` rises at `count=60`.
  - FULL, `memory_full=1`, `stop=1`, `in_ready=0`, `addr=0`.
- Word 63 sent with `in_last=1`: state is FULL, not DONE; `memory_full=1`.
- Assert `clear` after 10 accepted words, then `start` plus 2 words:
  - Writes land at addresses 0 and 1.
  - `count=2`; words 2..9 from the old fill are still readable.
- Assert `rst` mid-WRITE at `count=5` together with `in_valid`:
  - No write occurs that cycle.
  - All outputs return to reset values.
  - `start` and `clear` asserted in the same cycle leave the block in IDLE.
- With `MEM_FILL_CTRL_READBACK_EN`, write `0xDEADBEEF` to address 7, then set `rd_addr=7`:
  - `rd_data=0xDEADBEEF` one cycle later.
  - A same-cycle read/write to address 7 with `0x12345678` returns `0xDEADBEEF`.
